// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : UART frame loader that writes a program image into IMEM
// Rev 1.0
// ============================================================================
module imem_loader #(
    parameter int DEPTH   = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        load_err
);

    localparam int         IW   = $clog2(DEPTH + 1);
    localparam int         TW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  count, word_idx;
    logic [1:0]     byte_idx;
    logic [31:0]    word_buf;
    logic [7:0]     csum;
    logic [TW-1:0]  tcnt;
    logic           n_ok, last_wr, timed_out, timed_state;

    always_comb begin
        n_ok        = (rx_data != 8'd0) && ({24'd0, rx_data} <= 32'(DEPTH));
        // The last word's write pulse also ends the data phase; a byte in
        // that cycle is already the checksum.
        last_wr     = imem_we && (word_idx == count);
        timed_out   = !rx_valid && (tcnt == TW'(TIMEOUT - 1));
        timed_state = (state == COUNT) || (state == DATA) || (state == CHECK);
    end

    always_comb begin
        state_nx   = state;
        core_rst_n = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        load_err   = 1'b0;
        case (state)
            IDLE: begin
                core_rst_n = 1'b1;
                busy       = 1'b0;
                if (rx_valid && rx_data == SYNC) state_nx = COUNT;
            end
            COUNT: begin
                if (rx_valid)       state_nx = n_ok ? DATA : ERROR;
                else if (timed_out) state_nx = ERROR;
            end
            DATA: begin
                if (last_wr) begin
                    if (rx_valid)       state_nx = (rx_data == csum) ? DONE : ERROR;
                    else if (timed_out) state_nx = ERROR;
                    else                state_nx = CHECK;
                end else if (timed_out) begin
                    state_nx = ERROR;
                end
            end
            CHECK: begin
                if (rx_valid)       state_nx = (rx_data == csum) ? DONE : ERROR;
                else if (timed_out) state_nx = ERROR;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            ERROR: begin
                load_err = 1'b1;
                if (rx_valid && rx_data == SYNC) state_nx = COUNT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            csum      <= '0;
            tcnt      <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= '0;
        end else begin
            imem_we <= 1'b0;
            tcnt    <= (state_nx != state || rx_valid || !timed_state) ? '0 : tcnt + TW'(1);

            if (state == COUNT && rx_valid && n_ok) begin
                count    <= IW'(rx_data);
                word_idx <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end

            if (state == DATA && rx_valid && !last_wr) begin
                word_buf[8*byte_idx +: 8] <= rx_data;
                csum                      <= csum ^ rx_data;
                byte_idx                  <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    imem_we   <= 1'b1;
                    imem_addr <= 32'({word_idx, 2'b00});
                    imem_wd   <= {rx_data, word_buf[23:0]};
                    word_idx  <= word_idx + IW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 20: number of instruction-memory words that can be loaded.
REQ-002 Parameter TIMEOUT, default 1000000: maximum idle cycles allowed between bytes during a load.
REQ-003 CLK  in  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1: reset, asynchronous and active-low.
REQ-005 rx_valid  in  1: one-cycle strobe marking a byte received from the UART receiver.
REQ-006 rx_data  in  8: received byte, valid only when rx_valid=1.
REQ-007 imem_we  out  1: write strobe to the instruction memory's WE input.
REQ-008 imem_addr  out  32: byte address to the instruction memory's A input.
REQ-009 imem_wd  out  32: write data to the instruction memory's WD input.
REQ-010 core_rst_n  out  1: active-low reset to the core; low holds the core in reset while a load is in progress.
REQ-011 busy  out  1: high in every state except IDLE.
REQ-012 done  out  1: one-cycle pulse when a load completes successfully.
REQ-013 load_err  out  1: sticky error flag; high while in ERROR.

Function
REQ-014 Frame format: 0xA5 sync byte; count byte N (words, 1..DEPTH); N*4 data bytes, little-endian per word; checksum byte equal to the XOR of all data bytes.
REQ-015 The FSM states are IDLE, COUNT, DATA, CHECK, DONE and ERROR.
REQ-016 IDLE: rx_valid with 0xA5 -> COUNT; any other byte is ignored.
REQ-017 COUNT: a byte with N=0 or N>DEPTH -> ERROR; otherwise latch N, clear the word index, byte index and checksum, and go to DATA.
REQ-018 DATA: each accepted byte is shifted into word bits [8*byte_idx+7 : 8*byte_idx] and XORed into the checksum, and byte_idx increments modulo 4.
REQ-019 On the 4th byte of a word: exactly one cycle later, imem_we=1 for one cycle, with imem_addr={word_idx,2'b00} zero-extended and imem_wd=the assembled word; word_idx then increments.
REQ-020 After word N-1 is written -> CHECK; the first word goes to address 0 and the last to address 4*(N-1).
REQ-021 CHECK: a byte equal to the checksum -> DONE; a mismatch -> ERROR.
REQ-022 DONE lasts one cycle: done=1, then -> IDLE.
REQ-023 ERROR: load_err=1; only a 0xA5 byte leaves ERROR, going to COUNT and clearing load_err.
REQ-024 Timeout: in COUNT, DATA or CHECK, TIMEOUT consecutive cycles without rx_valid -> ERROR; the counter clears on every accepted byte and on every state entry.
REQ-025 core_rst_n=1 only in IDLE; it is 0 in COUNT, DATA, CHECK, DONE and ERROR, so a partial or corrupt image never runs.
REQ-026 imem_we is never asserted outside DATA; imem_addr and imem_wd hold their last value when imem_we=0.
REQ-027 rx_valid arriving in the same cycle as the imem_we pulse is accepted normally; no byte is lost.
REQ-028 A 0xA5 byte inside DATA or CHECK is treated as data or checksum, not as a resync.

Reset
REQ-029 While rst_n=0, regardless of CLK: state=IDLE, imem_we=0, imem_addr=0, imem_wd=0, core_rst_n=1, busy=0, done=0, load_err=0, and all indices, checksum and timeout counter are 0.
REQ-030 Reset asserted mid-load aborts the load immediately; words already written stay in memory, and no further write occurs.

Verification
REQ-031 Send A5,01,13,00,00,00,13 -> one imem_we pulse with addr=0 and wd=0x00000013, then done pulse, core_rst_n back to 1, load_err=0.
REQ-032 Send A5,02 plus two words 0x00100093 and 0x80000337 as LE bytes, then correct XOR -> writes at addr 0x0 then 0x4, done=1, exactly two imem_we pulses.
REQ-033 Send A5,01,13,00,00,00 then checksum 0xFF -> load_err=1 and core_rst_n stays 0; a following A5 clears load_err and returns to COUNT.
REQ-034 Send A5,00 and separately A5,15 with DEPTH=20 -> ERROR with no imem_we; send A5,01,13 then silence for TIMEOUT cycles -> ERROR.
REQ-035 Assert rst_n=0 after 2 of 4 data bytes -> all outputs at reset values within the same cycle; no write occurs; a fresh full frame afterwards loads correctly.
REQ-036 Send bytes 0x00 and 0x55 in IDLE -> no state change, busy=0, core_rst_n=1.
